// File: rtl/data_mem_ctrl.sv
// Byte-writable single-clock data memory with a self-clearing INIT phase and a registered read port.
// Optional macro DATA_MEM_CTRL_BYPASS_EN: same-address read/write returns write-first data (default read-first).
module data_mem_ctrl #(
  parameter int RAM_DEPTH  = 1024,
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   rd_en,
  input  logic [ADDR_WIDTH-1:0]  rd_addr,
  output logic [RAM_WIDTH-1:0]   rd_data,
  output logic                   rd_valid,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [RAM_WIDTH/8-1:0] wr_be,
  input  logic [RAM_WIDTH-1:0]   wr_data,
  output logic                   busy
);
  // state  | meaning
  // S_INIT | clearing word clr_q each cycle; ports ignored, busy=1
  // S_RUN  | normal read/write service until the next reset

  localparam int IDX_W = $clog2(RAM_DEPTH);
  localparam int NB    = RAM_WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RAM_DEPTH - 1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       clr_q, clr_d;
  logic [RAM_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [RAM_WIDTH-1:0]   mem [RAM_DEPTH];

  logic [IDX_W-1:0]       wr_idx, rd_idx, mem_idx;
  logic                   wr_in_range, rd_in_range, wr_fire, mem_we;
  logic [RAM_WIDTH-1:0]   rd_word, rd_fwd, mem_wdata;
  logic [NB-1:0]          mem_be;

  assign wr_idx = wr_addr[IDX_W-1:0];
  assign rd_idx = rd_addr[IDX_W-1:0];

  // Any set bit above the index field means the address is beyond the array.
  if (ADDR_WIDTH > IDX_W) begin : g_range
    assign wr_in_range = ~|wr_addr[ADDR_WIDTH-1:IDX_W];
    assign rd_in_range = ~|rd_addr[ADDR_WIDTH-1:IDX_W];
  end else begin : g_full
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
  end

  assign wr_fire = (state_q == S_RUN) && !stall && wr_en && wr_in_range;
  assign rd_word = rd_in_range ? mem[rd_idx] : '0;

`ifdef DATA_MEM_CTRL_BYPASS_EN
  always_comb begin
    rd_fwd = rd_word;
    if (wr_fire && rd_in_range && (wr_idx == rd_idx)) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) rd_fwd[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end
`else
  assign rd_fwd = rd_word;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      clr_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_d      = clr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    case (state_q)
      S_INIT: begin
        clr_d      = clr_q + 1'b1;
        rd_data_d  = '0;
        rd_valid_d = 1'b0;
        if (clr_q == LAST_IDX) state_d = S_RUN;
      end
      default: begin
        if (!stall) begin
          rd_valid_d = rd_en;
          if (rd_en) rd_data_d = rd_fwd;
        end
      end
    endcase
  end

  // One write port shared by the clearing sequence and normal writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = wr_idx;
    mem_wdata = wr_data;
    mem_be    = wr_be;
    if (state_q == S_INIT) begin
      mem_we    = !reset;
      mem_idx   = clr_q;
      mem_wdata = '0;
      mem_be    = '1;
    end else if (wr_fire) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = (state_q == S_INIT);

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter RAM_DEPTH, default 1024, meaning number of words (power of 2, at least 4).
REQ-002 The block SHALL have parameter RAM_WIDTH, default 32, meaning word width in bits (multiple of 8).
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 10, meaning address width in bits (at least log2(RAM_DEPTH)).
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port stall, input, 1, pipeline freeze.
REQ-007 The block SHALL have port rd_en, input, 1, read request.
REQ-008 The block SHALL have port rd_addr, input, ADDR_WIDTH, read word address.
REQ-009 The block SHALL have port rd_data, output, RAM_WIDTH, registered read data.
REQ-010 The block SHALL have port rd_valid, output, 1, rd_data holds a completed read.
REQ-011 The block SHALL have port wr_en, input, 1, write request.
REQ-012 The block SHALL have port wr_addr, input, ADDR_WIDTH, write word address.
REQ-013 The block SHALL have port wr_be, input, RAM_WIDTH/8, per-byte write enable; bit k covers bits 8k+7:8k.
REQ-014 The block SHALL have port wr_data, input, RAM_WIDTH, write data.
REQ-015 The block SHALL have port busy, output, 1, memory initialisation in progress.

Function
REQ-016 The block SHALL implement a two-state FSM: INIT and RUN.
REQ-017 In INIT the block SHALL write zero to the word at an internal clear pointer once per cycle, starting at pointer 0 and incrementing by 1 each cycle; stall has no effect in INIT.
REQ-018 The block SHALL move from INIT to RUN on the edge that clears word RAM_DEPTH-1, with busy=1 for exactly RAM_DEPTH cycles after reset deasserts.
REQ-019 In INIT the block SHALL ignore rd_en and wr_en and hold rd_valid=0 and rd_data=0.
REQ-020 In RUN with stall=0 and wr_en=1, the block SHALL update only the bytes of word wr_addr whose wr_be bit is 1; wr_be=0 is a no-op.
REQ-021 In RUN with stall=0 and rd_en=1, the block SHALL load rd_data with word rd_addr and set rd_valid=1 on the next edge (1-cycle latency).
REQ-022 In RUN with stall=0 and rd_en=0, the block SHALL clear rd_valid to 0 and hold rd_data.
REQ-023 With stall=1 in RUN, the block SHALL block writes and hold rd_data and rd_valid unchanged.
REQ-024 An address at or above RAM_DEPTH SHALL drop the write; a read of such an address SHALL return 0 with rd_valid=1.
REQ-025 A simultaneous read and write to the same address SHALL follow REQ-037.
REQ-026 Simultaneous read and write to different addresses SHALL both complete in the same cycle.
REQ-027 The RUN state SHALL persist until reset; no other transition exists.

Reset
REQ-028 While reset=1, the block SHALL hold the FSM in INIT, the clear pointer at 0, rd_data at 0, rd_valid at 0 and busy at 1.
REQ-029 Reset asserted mid-INIT or mid-RUN SHALL abort all activity.
REQ-030 After such a reset, initialisation SHALL restart from address 0 once reset deasserts.
REQ-031 Memory contents SHALL be defined only by the INIT sequence and SHALL NOT be cleared combinationally by reset.

Configuration
REQ-032 The macro DATA_MEM_CTRL_BYPASS_EN SHALL select the read-during-write behaviour.
REQ-033 With the macro defined, a same-address read and write SHALL be write-first: rd_data returns the old word with the enabled bytes replaced by wr_data.
REQ-034 With the macro undefined, a same-address read and write SHALL be read-first: rd_data returns the old word, and the write takes effect for later reads.
REQ-035 Under either setting, a read and write in the same cycle SHALL both complete.
REQ-036 The macro SHALL have no effect on any other behaviour.
REQ-037 The read-during-write result SHALL be as given by REQ-033 (macro defined) or REQ-034 (macro undefined).

Verification
REQ-038 Init: pulse reset, RAM_DEPTH=16 -> busy=1 for 16 cycles then 0; read of every address -> 0x00000000.
REQ-039 Byte write: write 0xAABBCCDD with be=0xF to addr 5, then 0x11223344 with be=0x5 -> read addr 5 one cycle later gives 0xAA22CC44, rd_valid=1.
REQ-040 Stall: issue a read of addr 5 (0xAA22CC44) and hold stall=1 for 3 cycles while wr_en=1, wr_addr=5, wr_data=0, be=0xF -> rd_data and rd_valid hold and addr 5 stays 0xAA22CC44.
REQ-041 Collision: with addr 3 = 0x0, read and write addr 3 with 0xFFFF0000 and be=0xC in the same cycle -> rd_data=0xFFFF0000 with the macro defined, 0x00000000 without it; the next read gives 0xFFFF0000 in both builds.
REQ-042 Reset mid-INIT: assert reset at clear pointer 7 -> busy stays 1, and after release exactly RAM_DEPTH busy cycles occur.
REQ-043 Out of range: with ADDR_WIDTH=5 and RAM_DEPTH=16, write 0x12345678 to addr 20 -> no word changes; read addr 20 -> 0, rd_valid=1.
